// File: rtl/adder_tree_sr.sv
// adder_tree_sr: pipelined signed adder tree with arithmetic shift, truncate/round-half-up,
// saturate/wrap to OUT_W bits and an overflow flag; valid and mode bits ride with the data.
module adder_tree_sr #(
   parameter int NUM_IN = 8,
   parameter int IN_W   = 14,
   parameter int OUT_W  = 12,
   parameter int SHIFT  = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   ce_i,
   input  logic                   in_valid_i,
   input  logic [NUM_IN*IN_W-1:0] din_i,
   input  logic                   rnd_mode_i,
   input  logic                   sat_en_i,
   output logic                   out_valid_o,
   output logic [OUT_W-1:0]       dout_o,
   output logic                   ovf_o
);
   localparam int L  = $clog2(NUM_IN);
   localparam int SW = IN_W + L;
   localparam logic signed [SW:0] HALF = (SW+1)'(SHIFT > 0 ? 1 << (SHIFT > 0 ? SHIFT - 1 : 0) : 0);
   localparam logic signed [SW:0] OMAX = (SW+1)'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [SW:0] OMIN = (SW+1)'(-(1 << (OUT_W - 1)));
   genvar k, i;
   for (k = 0; k < L; k++) begin : g_st
      localparam int N = NUM_IN >> (k + 1);
      localparam int W = IN_W + k + 1;
      logic signed [W-1:0] s_q [N];
      logic signed [W-1:0] s_d [N];
      logic                v_q, rnd_q, sat_q;
      logic                v_d, rnd_d, sat_d;
      for (i = 0; i < N; i++) begin : g_add
         if (k == 0) begin : g_in
            assign s_d[i] = W'($signed(din_i[2*i*IN_W +: IN_W])) + W'($signed(din_i[(2*i+1)*IN_W +: IN_W]));
         end else begin : g_mid
            assign s_d[i] = W'(g_st[k-1].s_q[2*i]) + W'(g_st[k-1].s_q[2*i+1]);
         end
      end
      if (k == 0) begin : g_vin
         assign v_d   = in_valid_i;
         assign rnd_d = rnd_mode_i;
         assign sat_d = sat_en_i;
      end else begin : g_vmid
         assign v_d   = g_st[k-1].v_q;
         assign rnd_d = g_st[k-1].rnd_q;
         assign sat_d = g_st[k-1].sat_q;
      end
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            s_q   <= '{default: '0};
            v_q   <= 1'b0;
            rnd_q <= 1'b0;
            sat_q <= 1'b0;
         end else if (ce_i) begin
            s_q   <= s_d;
            v_q   <= v_d;
            rnd_q <= rnd_d;
            sat_q <= sat_d;
         end
      end
   end
   logic signed [SW-1:0] sum;
   logic signed [SW:0]   rs, r;
   logic                 lv, lrnd, lsat, ovf_d;
   logic [OUT_W-1:0]     dout_d;
   logic                 out_valid_q, ovf_q;
   logic [OUT_W-1:0]     dout_q;
   assign sum  = g_st[L-1].s_q[0];
   assign lv   = g_st[L-1].v_q;
   assign lrnd = g_st[L-1].rnd_q;
   assign lsat = g_st[L-1].sat_q;
   // One extra bit keeps the rounding increment from overflowing the full-range sum.
   always_comb begin
      rs     = (SW+1)'(sum) + (lrnd ? HALF : (SW+1)'(0));
      r      = rs >>> SHIFT;
      ovf_d  = (r > OMAX) || (r < OMIN);
      dout_d = !(lsat && ovf_d) ? r[OUT_W-1:0] : (r > OMAX) ? OMAX[OUT_W-1:0] : OMIN[OUT_W-1:0];
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         ovf_q       <= 1'b0;
      end else if (ce_i) begin
         out_valid_q <= lv;
         if (lv) begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
         end
      end
   end
   assign out_valid_o = out_valid_q;
   assign dout_o      = dout_q;
   assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_adder_tree_sr.sv
// tb_adder_tree_sr: directed vectors for adder_tree_sr at default parameters;
// results are matched in order against a queue of expected {ovf, dout} values.
module tb_adder_tree_sr;
   localparam int N  = 8;
   localparam int IW = 14;
   localparam int OW = 12;
   logic            clk = 1'b0;
   logic            rst_n, ce, in_valid, rnd_mode, sat_en, out_valid, ovf;
   logic [N*IW-1:0] din;
   logic [OW-1:0]   dout;
   int              checks = 0;
   int              errors = 0;
   int              expq[$];
   string           tagq[$];
   logic [31:0]     pat = 32'hB2D9_6A4D;
   int              pi = 0;

   always #5 clk = ~clk;

   adder_tree_sr #(.NUM_IN(N), .IN_W(IW), .OUT_W(OW), .SHIFT(3)) dut (
      .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .in_valid_i(in_valid), .din_i(din),
      .rnd_mode_i(rnd_mode), .sat_en_i(sat_en), .out_valid_o(out_valid), .dout_o(dout), .ovf_o(ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] model(input logic [N*IW-1:0] d, input logic r, input logic s);
      longint sum, q;
      sum = 0;
      for (int j = 0; j < N; j++) sum += longint'($signed(d[j*IW +: IW]));
      q = (sum + (r ? 64'sd4 : 64'sd0)) >>> 3;
      if (q > 2047) return {1'b1, s ? 12'h7FF : q[11:0]};
      if (q < -2048) return {1'b1, s ? 12'h800 : q[11:0]};
      return {1'b0, q[11:0]};
   endfunction

   always @(posedge clk) begin : mon
      logic en;
      en = ce && rst_n;
      #1;
      if (en && out_valid) begin
         if (expq.size() == 0) check("spurious", 32'(out_valid), 32'd0);
         else check(tagq.pop_front(), 32'({ovf, dout}), 32'(expq.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input string tag, input logic [N*IW-1:0] d, input logic r, input logic s, input logic [12:0] e);
      in_valid = 1'b1;
      din = d;
      rnd_mode = r;
      sat_en = s;
      tagq.push_back(tag);
      expq.push_back(int'(e));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic stall_step();
      logic [13:0] pre;
      ce = pat[pi % 32];
      pi++;
      pre = {out_valid, ovf, dout};
      tick();
      if (!ce) check("frozen", 32'({out_valid, ovf, dout}), 32'(pre));
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b1; in_valid = 1'b1; din = {8{14'h0001}}; rnd_mode = 1'b0; sat_en = 1'b1;
      idle(2);
      check("rst_ov", 32'(out_valid), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("idle_ov", 32'(out_valid), 32'd0);
      end
      send("neg1",    {8{14'h3FFF}},                0, 1, 13'h0FFF);
      send("one",     {8{14'h0001}},                0, 1, 13'h0001);
      send("alt",     {4{14'h3FFF, 14'h0001}},      0, 1, 13'h0000);
      send("mixpair", {{4{14'h2001}}, {4{14'h1FFF}}}, 0, 1, 13'h0000);
      send("satp",    {8{14'h1FFF}},                0, 1, 13'h17FF);
      send("wrapp",   {8{14'h1FFF}},                0, 0, 13'h1FFF);
      send("satn",    {8{14'h2000}},                0, 1, 13'h1800);
      send("wrapn",   {8{14'h2000}},                0, 0, 13'h1000);
      send("tie_p_t", {{7{14'h0}}, 14'h0004},       0, 1, 13'h0000);
      send("tie_p_r", {{7{14'h0}}, 14'h0004},       1, 1, 13'h0001);
      send("tie_n_t", {{7{14'h0}}, 14'h3FF4},       0, 1, 13'h0FFE);
      send("tie_n_r", {{7{14'h0}}, 14'h3FF4},       1, 1, 13'h0FFF);
      send("round",   {4{14'h1555, 14'h2AAA}},      1, 1, 13'h0000);
      send("trunc",   {4{14'h1555, 14'h2AAA}},      0, 1, 13'h0FFF);
      idle(8);
      check("hold_ov", 32'(out_valid), 32'd0);
      check("hold_dout", 32'(dout), 32'h0FFF);
      check("hold_ovf", 32'(ovf), 32'd0);
      check("dir_drain", 32'(expq.size()), 32'd0);
      for (int s = 0; s < 8; s++) begin
         logic [N*IW-1:0] d;
         for (int j = 0; j < N; j++) d[j*IW +: IW] = 14'(s * 1237 + j * 2711 + s * j * 977);
         in_valid = 1'b1;
         din = d;
         rnd_mode = s[0];
         sat_en = s[1];
         tagq.push_back("stall");
         expq.push_back(int'(model(d, s[0], s[1])));
         do stall_step(); while (!ce);
      end
      in_valid = 1'b0;
      for (int t = 0; t < 60 && expq.size() > 0; t++) stall_step();
      ce = 1'b1;
      idle(2);
      check("stall_drain", 32'(expq.size()), 32'd0);
      send("lost0", {8{14'h0002}}, 0, 1, 13'h0002);
      send("lost1", {8{14'h0003}}, 0, 1, 13'h0003);
      send("lost2", {8{14'h0004}}, 0, 1, 13'h0004);
      rst_n = 1'b0;
      tick();
      expq.delete();
      tagq.delete();
      check("mrst_ov", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      send("post", {8{14'h0001}}, 0, 1, 13'h0001);
      check("post_lat0", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_lat", 32'(out_valid), 32'(i == 2));
      end
      idle(6);
      check("final_drain", 32'(expq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
